// File: rtl/mc_sequencer.sv
// Multi-cycle processor control sequencer: Moore FSM stepping each instruction
// through fetch, decode, execute, memory and writeback, driving datapath enables and selects.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instruction at PC, PC+4 on mem_ready
// DECODE   | read registers, compute branch target
// MEMADR   | compute load/store address
// MEMREAD  | load data from memory, wait for mem_ready
// MEMWB    | write loaded data to register file
// MEMWRITE | store data to memory, retire on mem_ready
// EXECR    | register-register ALU operation
// ALUWB    | write ALU result to register file
// EXECI    | register-immediate ALU operation
// JAL      | PC <= target, ALU forms return address
// BRANCH   | compare, PC <= target when taken
// ERROR    | unsupported opcode, hold until reset
module mc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = S_BRANCH;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite   = 1'b1;
        AdrSrc     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        PCWrite    = branch_taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ERROR: illegal = 1'b1;
      default: state_d = S_ERROR;
    endcase
    // Reset abandons the instruction in flight: no architectural writes, no retire pulse.
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: per-cycle vector table checked through an expectation queue,
// followed by a random stream checking memory exclusivity and IRWrite placement.
module tb_mc_sequencer;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready, branch_taken;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_done, illegal;
  logic [3:0] state;

  mc_sequencer dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       mr;
    logic       bt;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [15:0] outs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic [6:0] o, input logic mr,
                     input logic bt, input logic [3:0] st);
    vec_t v;
    v.rst = rst; v.op = o; v.mr = mr; v.bt = bt; v.st = st;
    vecs.push_back(v);
  endtask

  // Output word: {PCWrite,IRWrite,RegWrite,MemRead,MemWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,instr_done,illegal}
  function automatic logic [15:0] exp_out(input logic [3:0] st, input logic rst,
                                          input logic mr, input logic bt);
    logic pcw, irw, rw, mrd, mwr, adr, done, ill;
    logic [1:0] rs, a, b, alu;
    pcw = 0; irw = 0; rw = 0; mrd = 0; mwr = 0; adr = 0; done = 0; ill = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin mrd = 1; adr = 1; end
      4'd4:  begin rs = 2'b01; rw = 1; done = 1; end
      4'd5:  begin mwr = 1; adr = 1; done = mr; end
      4'd6:  begin a = 2'b10; alu = 2'b10; end
      4'd7:  begin rw = 1; done = 1; end
      4'd8:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      4'd9:  begin a = 2'b01; b = 2'b10; pcw = 1; end
      4'd10: begin a = 2'b10; alu = 2'b01; pcw = bt; done = 1; end
      4'd11: ill = 1;
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; rw = 0; mwr = 0; done = 0; end
    return {pcw, irw, rw, mrd, mwr, adr, rs, a, b, alu, done, ill};
  endfunction

  function automatic logic [15:0] act_out();
    return {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [15:0] got;
    reset = 1'b1; op = OP_R; mem_ready = 1'b1; branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    // R-type
    add(1, OP_R, 1, 0, 0);
    add(0, OP_R, 1, 0, 0); add(0, OP_R, 1, 0, 1); add(0, OP_R, 1, 0, 6); add(0, OP_R, 1, 0, 7);
    // lw with three wait cycles in MEMREAD
    add(0, OP_LW, 1, 0, 0); add(0, OP_LW, 1, 0, 1); add(0, OP_LW, 1, 0, 2);
    add(0, OP_LW, 0, 0, 3); add(0, OP_LW, 0, 0, 3); add(0, OP_LW, 0, 0, 3);
    add(0, OP_LW, 1, 0, 3); add(0, OP_LW, 1, 0, 4);
    // branch taken, then not taken
    add(0, OP_BR, 1, 1, 0); add(0, OP_BR, 1, 1, 1); add(0, OP_BR, 1, 1, 10);
    add(0, OP_BR, 1, 0, 0); add(0, OP_BR, 1, 0, 1); add(0, OP_BR, 1, 0, 10);
    // jal, I-type, sw
    add(0, OP_JAL, 1, 0, 0); add(0, OP_JAL, 1, 0, 1); add(0, OP_JAL, 1, 0, 9); add(0, OP_JAL, 1, 0, 7);
    add(0, OP_I, 1, 0, 0); add(0, OP_I, 1, 0, 1); add(0, OP_I, 1, 0, 8); add(0, OP_I, 1, 0, 7);
    add(0, OP_SW, 1, 0, 0); add(0, OP_SW, 1, 0, 1); add(0, OP_SW, 1, 0, 2); add(0, OP_SW, 1, 0, 5);
    // fetch waits on memory
    add(0, OP_BAD, 0, 0, 0); add(0, OP_BAD, 0, 1, 0); add(0, OP_BAD, 1, 0, 0);
    // illegal opcode, held 10 cycles under varied inputs, then reset clears it
    add(0, OP_BAD, 1, 0, 1);
    for (int i = 0; i < 10; i++) add(0, (i % 2) ? OP_R : OP_BAD, i[0], i[1], 11);
    add(1, OP_R, 1, 1, 11);
    add(0, OP_SW, 0, 0, 0);
    // reset while store waits on memory
    add(0, OP_SW, 1, 0, 0); add(0, OP_SW, 1, 0, 1); add(0, OP_SW, 1, 0, 2);
    add(0, OP_SW, 0, 0, 5); add(1, OP_SW, 0, 0, 5); add(0, OP_SW, 1, 0, 0);
    // reset while load waits on memory, with mem_ready arriving in the reset cycle
    add(0, OP_LW, 1, 0, 1); add(0, OP_LW, 1, 0, 2); add(0, OP_LW, 0, 0, 3);
    add(1, OP_LW, 1, 0, 3); add(0, OP_LW, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      reset = vecs[i].rst; op = vecs[i].op;
      mem_ready = vecs[i].mr; branch_taken = vecs[i].bt;
      e.idx = i; e.st = vecs[i].st;
      e.outs = exp_out(vecs[i].st, vecs[i].rst, vecs[i].mr, vecs[i].bt);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      got = act_out();
      n_tests++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL state vec%0d: got %0d expected %0d", e.idx, state, e.st);
      end
      n_tests++;
      if (got !== e.outs) begin
        n_fail++;
        $display("FAIL outputs vec%0d (state %0d): got %h expected %h", e.idx, e.st, got, e.outs);
      end
      @(posedge clk);
    end

    // Random stream: memory exclusivity, IRWrite confined to FETCH, reset gating
    for (int c = 0; c < 10000; c++) begin
      logic [6:0] ops [7];
      ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R; ops[3] = OP_I;
      ops[4] = OP_JAL; ops[5] = OP_BR; ops[6] = 7'($urandom);
      #1;
      op = ops[$urandom_range(0, 6)];
      mem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      reset = ($urandom_range(0, 63) == 0) || (state == 4'd11 && $urandom_range(0, 3) == 0);
      @(negedge clk);
      n_tests++;
      if (MemRead && MemWrite) begin
        n_fail++;
        $display("FAIL mem_excl cycle%0d: MemRead=%b MemWrite=%b required not both", c, MemRead, MemWrite);
      end
      n_tests++;
      if (IRWrite && state != 4'd0) begin
        n_fail++;
        $display("FAIL irwrite_fetch cycle%0d: IRWrite=1 in state %0d required state 0", c, state);
      end
      if (reset) begin
        n_tests++;
        if ({PCWrite, IRWrite, RegWrite, MemWrite, instr_done} !== 5'b0) begin
          n_fail++;
          $display("FAIL reset_gate cycle%0d: got %b expected 00000", c,
                   {PCWrite, IRWrite, RegWrite, MemWrite, instr_done});
        end
      end
      @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
